pipe_stage_reg: RTL and testbench

Parametrised pipeline boundary register generalising the fixed ID/EXE latch. It carries a DATA_W payload (operands, immediate, PC+4, register numbers, forwarding selects) and a CTRL_W control word (wreg, m2reg, wmem, aluc, shift, aluimm, branch, ...) through DEPTH register slices. It adds per-slice valid bits, stall (hold), flush (kill), bubble insertion and saturating stall/flush event counters. It is instantiated between any two stages, with DEPTH=1 for ID/EXE.

---
 rtl/pipe_pkg.sv | 49 ++++
 rtl/pipe_slice.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 126 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline boundary registers: control-word field map,
// forwarding select encodings, depth limit and small helpers.
package pipe_pkg;

    // Maximum number of register slices a boundary register may have.
    localparam int unsigned DEPTH_MAX = 4;

    // Width of the occupancy count (must hold 0..DEPTH_MAX).
    localparam int unsigned OCC_W = 3;

    // Control-word field offsets (bit positions inside the CTRL word).
    localparam int unsigned WREG_B   = 0;
    localparam int unsigned M2REG_B  = 1;
    localparam int unsigned WMEM_B   = 2;
    localparam int unsigned ALUC_LSB = 3;
    localparam int unsigned ALUC_W   = 4;
    localparam int unsigned SHIFT_B  = 7;
    localparam int unsigned ALUIMM_B = 8;
    localparam int unsigned BRANCH_B = 9;

    // Minimum control width that holds every named field.
    localparam int unsigned CTRL_W_MIN = BRANCH_B + 1;

    // Operand forwarding select encodings carried in the payload.
    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,   // value read from the register file
        FWD_EXE   = 2'd1,   // ALU result in EXE
        FWD_MEM   = 2'd2,   // ALU result in MEM
        FWD_MEMRD = 2'd3    // load data in MEM
    } fwd_sel_e;

    // Action taken by every slice on a clock edge.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_SHIFT = 2'd1,
        ACT_KILL  = 2'd2
    } slice_act_e;

    // Number of set bits in a padded slice valid vector.
    function automatic logic [OCC_W-1:0] valid_popcount(input logic [DEPTH_MAX-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(DEPTH_MAX); i++) begin
            n = n + OCC_W'(v[i]);
        end
        return n;
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_slice.sv
// One pipeline register slice: valid bit, control word and payload with
// load, hold and kill controls. Control is zeroed whenever valid is low.
module pipe_slice #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              kill,
    input  logic              d_valid,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // Valid/control register: kill beats load; a bubble loads a zero control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
        end else if (kill) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
        end else if (load) begin
            q_valid <= d_valid;
            q_ctrl  <= d_valid ? d_ctrl : '0;
        end
    end

    // Payload register: only a load changes it; kill leaves it as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data <= '0;
        end else if (load && !kill) begin
            q_data <= d_data;
        end
    end

endmodule : pipe_slice

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register: DEPTH slices of valid/ctrl/data
// with stall, flush, bubble insertion and saturating event counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slice_act_e          act_c;
    logic                load_c;
    logic                kill_c;
    logic                stall_inc_c;
    logic                valid_q [DEPTH];
    logic [CTRL_W-1:0]   ctrl_q  [DEPTH];
    logic [DATA_W-1:0]   data_q  [DEPTH];
    logic [DEPTH_MAX-1:0] valid_vec_c;

    // Per-edge action: flush, then stall, then shift.
    always_comb begin
        act_c       = ACT_SHIFT;
        stall_inc_c = 1'b0;
        if (flush) begin
            act_c = ACT_KILL;
        end else if (stall) begin
            act_c       = ACT_HOLD;
            stall_inc_c = 1'b1;
        end
        load_c = (act_c == ACT_SHIFT);
        kill_c = (act_c == ACT_KILL);
    end

    // Slice chain: slice 0 takes the input stage, slice k takes slice k-1.
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_slice
        if (g == 0) begin : g_head
            pipe_slice #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_slice (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (load_c),
                .kill    (kill_c),
                .d_valid (in_valid),
                .d_ctrl  (in_ctrl),
                .d_data  (in_data),
                .q_valid (valid_q[g]),
                .q_ctrl  (ctrl_q[g]),
                .q_data  (data_q[g])
            );
        end else begin : g_body
            pipe_slice #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_slice (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (load_c),
                .kill    (kill_c),
                .d_valid (valid_q[g-1]),
                .d_ctrl  (ctrl_q[g-1]),
                .d_data  (data_q[g-1]),
                .q_valid (valid_q[g]),
                .q_ctrl  (ctrl_q[g]),
                .q_data  (data_q[g])
            );
        end
    end

    // Last slice drives the outputs directly from its registers.
    assign out_valid = valid_q[DEPTH-1];
    assign out_ctrl  = ctrl_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    // Occupancy: popcount of the slice valid bits, padded to DEPTH_MAX.
    always_comb begin
        valid_vec_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            valid_vec_c[i] = valid_q[i];
        end
    end

    assign occupancy = valid_popcount(valid_vec_c);

    // Stall event counter: saturating, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall_inc_c && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Flush event counter: saturating, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            flush_cnt <= '0;
        end else if (flush && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: four instances (DEPTH 1/2/3 and a
// 4-bit-counter variant) share one stimulus set; expected values are fixed.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          stall;
    logic          flush;
    logic          cnt_clr;

    logic          d1_valid, d2_valid, d3_valid, c4_valid;
    logic [CW-1:0] d1_ctrl,  d2_ctrl,  d3_ctrl,  c4_ctrl;
    logic [DW-1:0] d1_data,  d2_data,  d3_data,  c4_data;
    logic [2:0]    d1_occ,   d2_occ,   d3_occ,   c4_occ;
    logic [15:0]   d1_scnt,  d2_scnt,  d3_scnt;
    logic [15:0]   d1_fcnt,  d2_fcnt,  d3_fcnt;
    logic [3:0]    c4_scnt,  c4_fcnt;

    int vectors;
    int miscompares;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1), .CNT_W(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_data(in_data), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(d1_valid), .out_ctrl(d1_ctrl), .out_data(d1_data),
        .occupancy(d1_occ), .stall_cnt(d1_scnt), .flush_cnt(d1_fcnt));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2), .CNT_W(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_data(in_data), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(d2_valid), .out_ctrl(d2_ctrl), .out_data(d2_data),
        .occupancy(d2_occ), .stall_cnt(d2_scnt), .flush_cnt(d2_fcnt));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(3), .CNT_W(16)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_data(in_data), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(d3_valid), .out_ctrl(d3_ctrl), .out_data(d3_data),
        .occupancy(d3_occ), .stall_cnt(d3_scnt), .flush_cnt(d3_fcnt));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2), .CNT_W(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_data(in_data), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(c4_valid), .out_ctrl(c4_ctrl), .out_data(c4_data),
        .occupancy(c4_occ), .stall_cnt(c4_scnt), .flush_cnt(c4_fcnt));

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every vector, reports any miscompare.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 ns before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the input stage for the next edge.
    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    // Reset across one edge, release on the falling edge.
    task automatic do_reset();
        drive(1'b0, '0, '0);
        stall   = 1'b0;
        flush   = 1'b0;
        cnt_clr = 1'b0;
        rst_n   = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(1'b0, '0, '0);
        stall   = 1'b0;
        flush   = 1'b0;
        cnt_clr = 1'b0;

        // Reset, DEPTH=1: asynchronous clear mid-cycle, then reload.
        do_reset();
        check("rst_d1_valid", 64'(d1_valid), 64'd0);
        check("rst_d3_occ",   64'(d3_occ),   64'd0);
        drive(1'b1, 16'hFFFF, 32'h0000_00A5);
        tick();
        check("load_d1_ctrl", 64'(d1_ctrl), 64'hFFFF);
        check("load_d1_data", 64'(d1_data), 64'hA5);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_d1_valid", 64'(d1_valid), 64'd0);
        check("async_d1_ctrl",  64'(d1_ctrl),  64'd0);
        check("async_d1_data",  64'(d1_data),  64'd0);
        check("async_d1_occ",   64'(d1_occ),   64'd0);
        tick();
        check("held_d1_valid", 64'(d1_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("relz_d1_valid", 64'(d1_valid), 64'd1);
        check("relz_d1_ctrl",  64'(d1_ctrl),  64'hFFFF);
        check("relz_d1_data",  64'(d1_data),  64'hA5);

        // Pass-through, DEPTH=3.
        do_reset();
        drive(1'b1, 16'h0011, 32'd1);
        tick();
        check("pt_occ1", 64'(d3_occ), 64'd1);
        check("pt_out_v1", 64'(d3_valid), 64'd0);
        drive(1'b1, 16'h0022, 32'd2);
        tick();
        check("pt_occ2", 64'(d3_occ), 64'd2);
        drive(1'b1, 16'h0033, 32'd3);
        tick();
        check("pt_occ3",   64'(d3_occ),  64'd3);
        check("pt_data_c3", 64'(d3_data), 64'd1);
        check("pt_ctrl_c3", 64'(d3_ctrl), 64'h0011);
        drive(1'b0, 16'h0000, 32'd0);
        tick();
        check("pt_data_c4", 64'(d3_data), 64'd2);
        tick();
        check("pt_data_c5", 64'(d3_data), 64'd3);
        check("pt_ctrl_c5", 64'(d3_ctrl), 64'h0033);
        check("pt_occ_c5",  64'(d3_occ),  64'd1);

        // Stall, DEPTH=2 full: four frozen cycles, then shifting resumes.
        do_reset();
        drive(1'b1, 16'h0101, 32'h10);
        tick();
        drive(1'b1, 16'h0202, 32'h20);
        tick();
        check("st_full_occ", 64'(d2_occ), 64'd2);
        drive(1'b1, 16'h0303, 32'h30);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("st_hold_data", 64'(d2_data), 64'h10);
            check("st_hold_ctrl", 64'(d2_ctrl), 64'h0101);
        end
        check("st_occ",  64'(d2_occ),  64'd2);
        check("st_cnt4", 64'(d2_scnt), 64'd4);
        check("st_fcnt", 64'(d2_fcnt), 64'd0);
        stall = 1'b0;
        tick();
        check("st_rel_data", 64'(d2_data), 64'h20);
        drive(1'b1, 16'h0404, 32'h40);
        tick();
        check("st_rel_data2", 64'(d2_data), 64'h30);
        check("st_rel_ctrl2", 64'(d2_ctrl), 64'h0303);

        // Bubble: valid=0 with all-ones control carries zero control.
        drive(1'b0, 16'hFFFF, 32'h55);
        tick();
        check("bub_d1_valid", 64'(d1_valid), 64'd0);
        check("bub_d1_ctrl",  64'(d1_ctrl),  64'd0);
        check("bub_d1_data",  64'(d1_data),  64'h55);
        check("bub_d2_data",  64'(d2_data),  64'h40);
        drive(1'b1, 16'h0606, 32'h66);
        tick();
        check("bub_d2_valid", 64'(d2_valid), 64'd0);
        check("bub_d2_ctrl",  64'(d2_ctrl),  64'd0);
        check("bub_d2_data",  64'(d2_data),  64'h55);
        check("bub_d2_occ",   64'(d2_occ),   64'd1);

        // Flush plus stall, DEPTH=3 full.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0F0F, 32'h71 + 32'(i));
            tick();
        end
        check("fl_full_occ", 64'(d3_occ), 64'd3);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, '0, '0);
        check("fl_occ",   64'(d3_occ),   64'd0);
        check("fl_valid", 64'(d3_valid), 64'd0);
        check("fl_ctrl",  64'(d3_ctrl),  64'd0);
        check("fl_data",  64'(d3_data),  64'h71);
        check("fl_fcnt",  64'(d3_fcnt),  64'd1);
        check("fl_scnt",  64'(d3_scnt),  64'd0);

        // Reset during a flush clears counters at once; no resume after.
        flush = 1'b1;
        tick();
        check("rf_fcnt2", 64'(d3_fcnt), 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("rf_fcnt_clr", 64'(d3_fcnt), 64'd0);
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'h0077, 32'h77);
        tick();
        check("rf_occ",  64'(d3_occ),  64'd1);
        check("rf_fcnt", 64'(d3_fcnt), 64'd0);

        // Counter saturation with CNT_W=4, then clear beats increment.
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("sat_c4_scnt",  64'(c4_scnt), 64'd15);
        check("sat_d2_scnt",  64'(d2_scnt), 64'd20);
        cnt_clr = 1'b1;
        tick();
        check("clr_c4_scnt",  64'(c4_scnt), 64'd0);
        check("clr_d2_scnt",  64'(d2_scnt), 64'd0);
        cnt_clr = 1'b0;
        tick();
        check("inc_c4_scnt",  64'(c4_scnt), 64'd1);
        check("inc_c4_fcnt",  64'(c4_fcnt), 64'd0);
        stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pipe_stage_reg
